bin2bcd_conv: RTL and testbench
===============================

# bin2bcd_conv

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display driver. It captures a binary value on a start strobe and converts it with a shift-and-add-3 (double-dabble) iteration, one bit per clock. It presents a registered packed-BCD word that the display stage decodes digit by digit. A one-cycle done pulse marks each new result; the result is held stable between conversions.

## Interface
- WIDTH, 32: binary input width in bits.
- DIGITS, 10: number of BCD output digits; 10^DIGITS > 2^WIDTH−1 is required, and smaller values are unsupported.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bin_in  input  WIDTH  unsigned binary value, sampled only on an accepted start.
- start  input  1  conversion request, level-sampled each edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].

## Operation
- FSM states:
  - IDLE: accepts start.
  - SHIFT: runs the conversion iterations.
  - FIN: transfers the result to bcd_out.
- IDLE + start=1:
  - Load the working register {DIGITS*4 zeros, bin_in}.
  - Clear the iteration counter, set busy=1, go to SHIFT.
- IDLE + start=0: remain in IDLE.
- SHIFT, one iteration per edge:
  - Each 4-bit digit field of the working register that is ≥5 gets +3, with 4-bit wraparound-free arithmetic since the max result is 12.
  - Then the whole register shifts left by 1.
  - The counter increments; after WIDTH iterations, go to FIN.
- FIN:
  - bcd_out <= upper 4*DIGITS bits of the working register.
  - done <= 1, busy <= 0, go to IDLE.
- start while busy (SHIFT or FIN) is ignored, with no queueing. bin_in changes after acceptance have no effect.
- Counter width is clog2(WIDTH+1), and it never wraps within a conversion.
- bcd_out changes only in the FIN transfer and on reset.
- Reset mid-conversion:
  - Immediate return to IDLE with busy=0, done=0, and bcd_out at its reset value.
  - No done pulse follows; the partial result is discarded.

## Timing
- Reset values:
  - busy=0, done=0, state IDLE, counter 0.
  - bcd_out all zeros, or the blanked-zero pattern when BIN2BCD_BLANK_EN is defined.
- Latency, with start sampled at edge E:
  - busy is high from E+0 until edge E+WIDTH+1.
  - done is high for exactly the one cycle following edge E+WIDTH+1, with the new bcd_out valid in that same cycle.
  - For WIDTH=32, done is visible 33 cycles after the accepting edge.
- Throughput: a start asserted while done is high is accepted, because the state is already IDLE. Back-to-back conversions therefore take WIDTH+2 cycles each.
- done and busy are never both high.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - In the FIN transfer, every digit above the most significant non-zero digit is replaced by 4'hF. The display stage renders 4'hF as blank.
  - Digit 0 is never blanked, so value 0 gives {F…F,0}.
  - The reset value is the same blanked-zero pattern.
- BIN2BCD_BLANK_EN undefined: all digits are passed through, leading zeros included, and the reset value is all zeros.
- Latency is identical in both builds; blanking is combinational in the FIN transfer path.

## Structure
- Package bin2bcd_pkg contains:
  - state encoding constants for IDLE/SHIFT/FIN;
  - BLANK_NIBBLE = 4'hF;
  - default WIDTH/DIGITS values;
  - the digit-correction threshold 4'd5 and increment 4'd3.
- Sub-module bcd_adj3 is the single-digit combinational correction (in ≥5 → in+3, else in). It is instantiated DIGITS times through a generate loop on the working register's BCD fields.
- Leading-zero blanking is a priority scan from the top digit down, placed inside the top level under the macro.

## Test plan
- bin_in=255, start for one cycle:
  - busy is high for 33 cycles, then done pulses for 1 cycle.
  - bcd_out=40'h0000000255 without the macro, and 40'hFFFFFFF255 with it.
- bin_in=32'hFFFFFFFF: bcd_out=40'h4294967295, with done exactly 33 cycles after the accepting edge.
- bin_in=0: bcd_out=40'h0000000000 without the macro, and 40'hFFFFFFFFF0 with it.
- start=1 at the accepting edge with bin_in=123, then start re-pulsed with bin_in=999 at cycle 10:
  - Only one done pulse occurs, and bcd_out encodes 123.
  - start asserted in the done cycle with bin_in=999 yields a second done 34 cycles after the first, encoding 999.
- rst asserted at cycle 15 of a conversion of 5000:
  - busy, done, and bcd_out go to their reset values immediately.
  - No done pulse occurs; a fresh start then converts correctly.
- Hold start=1 continuously with bin_in=42:
  - done pulses every 34 cycles.
  - busy is low only in the done cycles.
  - bcd_out is stable at 42 between pulses.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, default sizing, the double-dabble correction constants
// and the nibble code the display stage renders as a blank digit.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DIGITS = 10;

    // A digit >= 5 would overflow past 9 once doubled, so it is pre-corrected by +3.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_INC    = 4'd3;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/bcd_adj3.sv
// Single-digit double-dabble correction: a digit of 5..9 gets +3 before the
// register shifts. The largest result is 12, so 4 bits never wrap.
module bcd_adj3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? (din + ADJ_INC) : din;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start in IDLE captures bin_in; WIDTH shift iterations follow; the FIN
// state transfers the BCD field to bcd_out and pulses done for one cycle.
// Optional build macro BIN2BCD_BLANK_EN: leading zero digits above the most
// significant non-zero digit are replaced by 4'hF (digit 0 is never blanked),
// and the reset value of bcd_out becomes the blanked-zero pattern.
module bin2bcd_conv
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int REG_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [BCD_W-1:0] BCD_RST = {{(DIGITS-1){BLANK_NIBBLE}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] BCD_RST = '0;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [REG_W-1:0]   work;
    logic [REG_W-1:0]   work_adj;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_fin;

    // Per-digit +3 correction on the BCD fields sitting above the binary part.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (work[WIDTH + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // The binary part passes unchanged; the whole register then shifts left by one.
    assign work_adj = {bcd_adj, work[WIDTH-1:0]};

`ifdef BIN2BCD_BLANK_EN
    // Scan from the top digit down, blanking zeros until the first non-zero digit.
    function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             seen;
        r    = v;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (!seen && (v[4*i +: 4] == 4'h0)) begin
                r[4*i +: 4] = BLANK_NIBBLE;
            end else begin
                seen = 1'b1;
            end
        end
        return r;
    endfunction

    assign bcd_fin = blank_lead(work[REG_W-1:WIDTH]);
`else
    assign bcd_fin = work[REG_W-1:WIDTH];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control and result registers: busy, done pulse, iteration counter, bcd_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            bcd_out <= BCD_RST;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + 1'b1;
                end
                ST_FIN: begin
                    bcd_out <= bcd_fin;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // Working register: loaded on an accepted start, corrected and shifted in SHIFT.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            work <= {{BCD_W{1'b0}}, bin_in};
        end else if (state == ST_SHIFT) begin
            work <= work_adj << 1;
        end
    end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed + randomized bench for bin2bcd_conv (WIDTH=32, DIGITS=10).
// Expected BCD words come from decimal arithmetic on the input value.
module tb_bin2bcd_conv;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic                clk;
    logic                rst;
    logic [WIDTH-1:0]    bin_in;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;

    int checks   = 0;
    int failures = 0;

    bin2bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal expansion of v; optionally blank digits above the leading one.
    function automatic logic [4*DIGITS-1:0] model(input logic [WIDTH-1:0] v);
        longint unsigned x;
        longint unsigned p;
        logic [4*DIGITS-1:0] r;
        x = longint'(v);
        p = 1;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((x / p) % 10);
`ifdef BIN2BCD_BLANK_EN
            if (i > 0 && x < p) r[4*i +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; advances negedges until done is seen or the limit runs out.
    task automatic wait_done(input int limit, output int n, output int busy_cnt, output int moved,
                             input logic [4*DIGITS-1:0] hold);
        n = 0; busy_cnt = 0; moved = 0;
        while (!done && n < limit) begin
            if (busy) busy_cnt++;
            if (bcd_out !== hold) moved++;
            @(negedge clk);
            n++;
        end
    endtask

    // Full conversion with latency, busy-length, hold-stability and result checks.
    task automatic do_conv(input logic [WIDTH-1:0] v, input string tag);
        int n, bc, mv;
        logic [4*DIGITS-1:0] prev;
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        prev   = bcd_out;
        @(negedge clk);
        start  = 1'b0;
        bin_in = $urandom;
        wait_done(100, n, bc, mv, prev);
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_len"}, 64'(bc), 64'd33);
        chk({tag, "_hold"}, 64'(mv), 64'd0);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(model(v)));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, bc, mv, pulses;
        logic [4*DIGITS-1:0] got;
        logic [WIDTH-1:0] rv;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd",  64'(bcd_out), 64'(model('0)));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner values.
        do_conv(32'd255, "v255");
        do_conv(32'hFFFF_FFFF, "vmax");
        do_conv(32'd0, "vzero");

        // Start re-pulsed while busy must be ignored.
        @(negedge clk);
        bin_in = 32'd123;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        got    = '0;
        for (int c = 1; c < 60; c++) begin
            if (c == 10) begin bin_in = 32'd999; start = 1'b1; end
            if (c == 11) start = 1'b0;
            if (done) begin pulses++; got = bcd_out; end
            @(negedge clk);
        end
        chk("busy_start_pulses", 64'(pulses), 64'd1);
        chk("busy_start_bcd", 64'(got), 64'(model(32'd123)));

        // Start in the done cycle is accepted: second done 34 cycles after the first.
        @(negedge clk);
        bin_in = 32'd123;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(100, n, bc, mv, bcd_out);
        chk("b2b_first_bcd", 64'(bcd_out), 64'(model(32'd123)));
        bin_in = 32'd999;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(100, n, bc, mv, bcd_out);
        chk("b2b_gap", 64'(n + 1), 64'd34);
        chk("b2b_second_bcd", 64'(bcd_out), 64'(model(32'd999)));

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin_in = 32'd5000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_bcd",  64'(bcd_out), 64'(model('0)));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);
        do_conv(32'd5000, "after_rst");

        // Start held high: periodic done, busy low only in done cycles, stable result.
        @(negedge clk);
        bin_in = 32'd42;
        start  = 1'b1;
        wait_done(100, n, bc, mv, bcd_out);
        chk("hold_first_bcd", 64'(bcd_out), 64'(model(32'd42)));
        bc = 0; mv = 0; pulses = 0;
        for (int c = 1; c <= 3 * 34; c++) begin
            @(negedge clk);
            if (busy === done) bc++;
            if (bcd_out !== model(32'd42)) mv++;
            if (done) begin
                pulses++;
                chk("hold_period", 64'(c % 34), 64'd0);
            end
        end
        chk("hold_pulses", 64'(pulses), 64'd3);
        chk("hold_busy_done_excl", 64'(bc), 64'd0);
        chk("hold_stable", 64'(mv), 64'd0);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized values across magnitudes.
        for (int k = 0; k < 10; k++) begin
            case (k % 3)
                0: rv = $urandom_range(0, 99);
                1: rv = $urandom_range(0, 999999);
                default: rv = $urandom;
            endcase
            do_conv(rv, $sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
